// File: rtl/mul_wb_pkg.sv
// Shared types for the multiplier writeback buffer: entry format, head states, head classifier.
// Optional MUL_WB_SAT_EN (used by mul_wb_buf) makes overflowed products write all-ones before raising the exception.
package mul_wb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
    logic                  ovf;
  } wb_entry_t;

  typedef enum logic [1:0] {IDLE, WRITE, DROP, EXC} head_state_t;

  // State a freshly exposed head entry starts in.
  function automatic head_state_t classify(wb_entry_t e, logic sat_en);
    if (e.ovf) return (sat_en && e.rd != '0) ? WRITE : EXC;
    return (e.rd != '0) ? WRITE : DROP;
  endfunction

endpackage

// File: rtl/mul_wb_buf_if.sv
// Multiplier-result input, register-file write port and overflow exception handshake.
// slave = the writeback buffer, master = the surrounding pipeline.
interface mul_wb_buf_if import mul_wb_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd_addr;
  logic [DATA_W-1:0] in_result;
  logic [DATA_W-1:0] in_carry;
  logic              rf_we;
  logic              rf_grant;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              exc_valid;
  logic [ADDR_W-1:0] exc_rd_addr;
  logic              exc_ack;

  modport master (
    output in_valid, in_rd_addr, in_result, in_carry, rf_grant, exc_ack,
    input  in_ready, rf_we, rf_waddr, rf_wdata, exc_valid, exc_rd_addr
  );

  modport slave (
    input  in_valid, in_rd_addr, in_result, in_carry, rf_grant, exc_ack,
    output in_ready, rf_we, rf_waddr, rf_wdata, exc_valid, exc_rd_addr
  );
endinterface

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO; head and the entry behind it are readable from registers (zero read latency).
// Push ignored when full, pop ignored when empty; caller owns flow control.
module wb_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  T              push_dat,
  input  logic          pop,
  output T              head_dat,
  output T              next_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] nxt_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign nxt_ptr = rd_ptr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= nxt_ptr;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign next_dat = mem[nxt_ptr];
endmodule

// File: rtl/mul_wb_buf.sv
// Multiplier writeback buffer: FIFO of {rd, product, ovf}, drained to the RF port or the exception port; 1-cycle latency.
// in_ready = not full from registered count; head holds until rf_grant / exc_ack. `define MUL_WB_SAT_EN: overflow writes 16'hFFFF first.
module mul_wb_buf import mul_wb_pkg::*; #(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  ADDR_W = ADDR_W_DEF,
  parameter int  DEPTH  = 4,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_wb_buf_if.slave   bus,
  output logic [CW-1:0] count,
  output logic [7:0]    ovf_cnt
);
`ifdef MUL_WB_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  wb_entry_t         in_ent;
  wb_entry_t         head;
  wb_entry_t         next_head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  head_state_t       state_q;
  head_state_t       state_d;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              exc_valid;
  logic [ADDR_W-1:0] exc_rd_addr;

  assign in_ent = '{rd: bus.in_rd_addr, data: bus.in_result, ovf: (bus.in_carry != '0)};
  assign push   = bus.in_valid && !full;

  wb_fifo #(.T(wb_entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (in_ent),
    .pop      (pop),
    .head_dat (head),
    .next_dat (next_head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    exc_valid   = 1'b0;
    exc_rd_addr = '0;
    case (state_q)
      WRITE: begin
        rf_we    = 1'b1;
        rf_waddr = head.rd;
        rf_wdata = (SAT_EN && head.ovf) ? '1 : head.data;
        if (bus.rf_grant) begin
          // A saturated overflow still owes its exception after the write.
          if (SAT_EN && head.ovf) state_d = EXC;
          else                    pop     = 1'b1;
        end
      end
      DROP: pop = 1'b1;
      EXC: begin
        exc_valid   = 1'b1;
        exc_rd_addr = head.rd;
        pop         = bus.exc_ack;
      end
      default: ;
    endcase
    // On a pop the next head is either the entry behind it or the one arriving this cycle.
    if (pop) begin
      if (count > CW'(1)) state_d = classify(next_head, SAT_EN);
      else if (push)      state_d = classify(in_ent, SAT_EN);
      else                state_d = IDLE;
    end else if (state_q == IDLE && push) begin
      state_d = classify(in_ent, SAT_EN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   ovf_cnt <= '0;
    else if (push && in_ent.ovf && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 8'd1;
  end

  assign bus.in_ready    = !full;
  assign bus.rf_we       = rf_we;
  assign bus.rf_waddr    = rf_waddr;
  assign bus.rf_wdata    = rf_wdata;
  assign bus.exc_valid   = exc_valid;
  assign bus.exc_rd_addr = exc_rd_addr;
endmodule

// File: tb/tb_mul_wb_buf.sv
// Directed and randomized checks of mul_wb_buf against a queue-based model of the writeback rules.
module tb_mul_wb_buf;
  localparam int DEPTH = 4;
`ifdef MUL_WB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, rf_grant, exc_ack;
  logic [2:0]  in_rd_addr;
  logic [15:0] in_result, in_carry;
  logic [2:0]  count;
  logic [7:0]  ovf_cnt;
  int          n_checks = 0;
  int          n_pass = 0;

  mul_wb_buf_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  assign bus.in_valid   = in_valid;
  assign bus.in_rd_addr = in_rd_addr;
  assign bus.in_result  = in_result;
  assign bus.in_carry   = in_carry;
  assign bus.rf_grant   = rf_grant;
  assign bus.exc_ack    = exc_ack;

  mul_wb_buf #(.DATA_W(16), .ADDR_W(3), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .count   (count),
    .ovf_cnt (ovf_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: pending entries in order, overflow tally, and whether the head's saturated write is done.
  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
    bit          ovf;
  } m_ent_t;
  m_ent_t q[$];
  int     m_ovf;
  bit     m_sat_done;

  function automatic void m_reset();
    q.delete();
    m_ovf      = 0;
    m_sat_done = 0;
  endfunction

  function automatic void model_edge();
    bit     do_pop = 0;
    bit     room   = (q.size() < DEPTH);
    m_ent_t h;
    m_ent_t n;
    if (q.size() != 0) begin
      h = q[0];
      if (h.ovf) begin
        if (SAT && h.rd != 0 && !m_sat_done) begin
          if (rf_grant) m_sat_done = 1;
        end else if (exc_ack) do_pop = 1;
      end else if (h.rd != 0) do_pop = rf_grant;
      else do_pop = 1;
    end
    if (do_pop) begin
      void'(q.pop_front());
      m_sat_done = 0;
    end
    if (in_valid && room) begin
      n.rd = in_rd_addr; n.data = in_result; n.ovf = (in_carry != 0);
      q.push_back(n);
      if (n.ovf && m_ovf < 255) m_ovf++;
    end
  endfunction

  // {in_ready, rf_we, rf_waddr, rf_wdata, exc_valid, exc_rd_addr, count, ovf_cnt}
  function automatic logic [35:0] model_out();
    logic        we = 0, ev = 0;
    logic [2:0]  wa = 0, ea = 0;
    logic [15:0] wd = 0;
    if (q.size() != 0) begin
      if (q[0].ovf) begin
        if (SAT && q[0].rd != 0 && !m_sat_done) begin
          we = 1; wa = q[0].rd; wd = 16'hFFFF;
        end else begin
          ev = 1; ea = q[0].rd;
        end
      end else if (q[0].rd != 0) begin
        we = 1; wa = q[0].rd; wd = q[0].data;
      end
    end
    return {(q.size() < DEPTH), we, wa, wd, ev, ea, 3'(q.size()), 8'(m_ovf)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] rd, input logic [15:0] res, input logic [15:0] cy);
    in_valid = v; in_rd_addr = rd; in_result = res; in_carry = cy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rf_grant = 0; exc_ack = 0;
    drive(0, 0, 0, 0);
    m_reset();
    #7;
    n_checks++;
    if ({bus.rf_we, bus.exc_valid, bus.rf_waddr, bus.rf_wdata, bus.exc_rd_addr, count, ovf_cnt} !== '0)
      $display("FAIL reset_outputs got we=%b exc=%b wa=%0d wd=%h ea=%0d cnt=%0d ovf=%0d expected all 0",
               bus.rf_we, bus.exc_valid, bus.rf_waddr, bus.rf_wdata, bus.exc_rd_addr, count, ovf_cnt);
    else n_pass++;
    #1 rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1 || count !== 3'd0)
      $display("FAIL reset_idle got in_ready=%b count=%0d expected 1/0", bus.in_ready, count);
    else n_pass++;
  endtask

  task automatic test_single_write();
    rf_grant = 1;
    drive(1, 3'd3, 16'h0024, 16'h0000);
    tick();
    drive(0, 0, 0, 0);
    n_checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, count} !== {1'b1, 3'd3, 16'h0024, 3'd1})
      $display("FAIL single_write got we=%b wa=%0d wd=%h cnt=%0d expected 1/3/0024/1",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata, count);
    else n_pass++;
    tick();
    n_checks++;
    if (count !== 3'd0 || bus.rf_we !== 1'b0)
      $display("FAIL single_drain got cnt=%0d we=%b expected 0/0", count, bus.rf_we);
    else n_pass++;
  endtask

  task automatic test_full();
    rf_grant = 0;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 3'(i), 16'h0100 + 16'(i), 0);
      tick();
    end
    n_checks++;
    if (count !== 3'd4 || bus.in_ready !== 1'b0)
      $display("FAIL full_state got cnt=%0d in_ready=%b expected 4/0", count, bus.in_ready);
    else n_pass++;
    drive(1, 3'd7, 16'hBEEF, 0);
    tick();
    drive(0, 0, 0, 0);
    n_checks++;
    if (count !== 3'd4) $display("FAIL full_reject got cnt=%0d expected 4", count);
    else n_pass++;
    rf_grant = 1;
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 3'(i), 16'h0100 + 16'(i)})
        $display("FAIL full_order_%0d got we=%b wa=%0d wd=%h expected 1/%0d/%h",
                 i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, i, 16'h0100 + 16'(i));
      else n_pass++;
      tick();
      if (i == 1) begin
        n_checks++;
        if (bus.in_ready !== 1'b1 || count !== 3'd3)
          $display("FAIL full_first_pop got in_ready=%b cnt=%0d expected 1/3", bus.in_ready, count);
        else n_pass++;
      end
    end
    n_checks++;
    if (count !== 3'd0 || bus.rf_we !== 1'b0)
      $display("FAIL full_drained got cnt=%0d we=%b expected 0/0", count, bus.rf_we);
    else n_pass++;
  endtask

  task automatic test_exception();
    rf_grant = 1; exc_ack = 0;
    drive(1, 3'd5, 16'h1234, 16'h0001);
    tick();
    drive(1, 3'd2, 16'h0007, 16'h0000);
    tick();
    drive(0, 0, 0, 0);
    n_checks++;
    if ({bus.exc_valid, bus.exc_rd_addr, bus.rf_we, count, ovf_cnt} !== {1'b1, 3'd5, 1'b0, 3'd2, 8'd1})
      $display("FAIL exc_raise got exc=%b ea=%0d we=%b cnt=%0d ovf=%0d expected 1/5/0/2/1",
               bus.exc_valid, bus.exc_rd_addr, bus.rf_we, count, ovf_cnt);
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (bus.exc_valid !== 1'b1 || bus.rf_we !== 1'b0 || count !== 3'd2)
      $display("FAIL exc_blocks got exc=%b we=%b cnt=%0d expected 1/0/2", bus.exc_valid, bus.rf_we, count);
    else n_pass++;
    exc_ack = 1;
    tick();
    exc_ack = 0;
    n_checks++;
    if ({bus.exc_valid, bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 1'b1, 3'd2, 16'h0007})
      $display("FAIL exc_then_write got exc=%b we=%b wa=%0d wd=%h expected 0/1/2/0007",
               bus.exc_valid, bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    else n_pass++;
    tick();
    n_checks++;
    if (count !== 3'd0) $display("FAIL exc_drained got cnt=%0d expected 0", count);
    else n_pass++;
  endtask

  task automatic test_drop();
    rf_grant = 0; exc_ack = 0;
    drive(1, 3'd0, 16'h0009, 16'h0000);
    tick();
    drive(0, 0, 0, 0);
    n_checks++;
    if ({bus.rf_we, bus.exc_valid, count} !== {1'b0, 1'b0, 3'd1})
      $display("FAIL drop_hold got we=%b exc=%b cnt=%0d expected 0/0/1", bus.rf_we, bus.exc_valid, count);
    else n_pass++;
    tick();
    n_checks++;
    if (count !== 3'd0 || bus.rf_we !== 1'b0)
      $display("FAIL drop_pop got cnt=%0d we=%b expected 0/0", count, bus.rf_we);
    else n_pass++;
  endtask

  task automatic test_sat();
    rf_grant = 0; exc_ack = 0;
    drive(1, 3'd4, 16'h0055, 16'h0002);
    tick();
    drive(0, 0, 0, 0);
    tick();
    n_checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.exc_valid} !== {1'b1, 3'd4, 16'hFFFF, 1'b0})
      $display("FAIL sat_write got we=%b wa=%0d wd=%h exc=%b expected 1/4/ffff/0",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.exc_valid);
    else n_pass++;
    rf_grant = 1;
    tick();
    rf_grant = 0;
    n_checks++;
    if ({bus.exc_valid, bus.exc_rd_addr, bus.rf_we, count} !== {1'b1, 3'd4, 1'b0, 3'd1})
      $display("FAIL sat_exc got exc=%b ea=%0d we=%b cnt=%0d expected 1/4/0/1",
               bus.exc_valid, bus.exc_rd_addr, bus.rf_we, count);
    else n_pass++;
    exc_ack = 1;
    tick();
    exc_ack = 0;
    n_checks++;
    if (count !== 3'd0 || bus.exc_valid !== 1'b0)
      $display("FAIL sat_pop got cnt=%0d exc=%b expected 0/0", count, bus.exc_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    rf_grant = 0; exc_ack = 0;
    drive(1, 3'd6, 16'h0001, 16'h0003); tick();
    drive(1, 3'd1, 16'h0011, 16'h0000); tick();
    drive(1, 3'd2, 16'h0022, 16'h0000); tick();
    drive(0, 0, 0, 0);
    n_checks++;
    if (count !== 3'd3 || (bus.exc_valid | bus.rf_we) !== 1'b1)
      $display("FAIL mid_setup got cnt=%0d exc=%b we=%b expected 3 with a pending head",
               count, bus.exc_valid, bus.rf_we);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.rf_we, bus.exc_valid, bus.rf_waddr, bus.rf_wdata, bus.exc_rd_addr, count, ovf_cnt} !== '0)
      $display("FAIL mid_reset got we=%b exc=%b wa=%0d wd=%h ea=%0d cnt=%0d ovf=%0d expected all 0",
               bus.rf_we, bus.exc_valid, bus.rf_waddr, bus.rf_wdata, bus.exc_rd_addr, count, ovf_cnt);
    else n_pass++;
    m_reset();
    rst_n = 1'b1;
    rf_grant = 1; exc_ack = 1;
    tick();
    n_checks++;
    if (count !== 3'd0 || bus.in_ready !== 1'b1)
      $display("FAIL mid_after got cnt=%0d in_ready=%b expected 0/1", count, bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [35:0] got, exp;
    int          errs = 0;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), 16'($urandom),
            ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0);
      rf_grant = $urandom_range(0, 1);
      exc_ack  = ($urandom_range(0, 9) < 4);
      tick();
      got = {bus.in_ready, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.exc_valid, bus.exc_rd_addr, count, ovf_cnt};
      exp = model_out();
      n_checks++;
      if (got !== exp) begin
        errs++;
        if (errs <= 10) $display("FAIL random_cycle_%0d got %h expected %h", c, got, exp);
      end else n_pass++;
    end
    drive(0, 0, 0, 0);
    rf_grant = 1; exc_ack = 1;
    repeat (10) tick();
    n_checks++;
    if (count !== 3'd0) $display("FAIL random_drain got cnt=%0d expected 0", count);
    else n_pass++;
  endtask

  task automatic test_ovf_saturate();
    rf_grant = 0; exc_ack = 1;
    for (int i = 0; i < 300; i++) begin
      drive(1, 3'd0, 16'($urandom), 16'h8000);
      tick();
    end
    drive(0, 0, 0, 0);
    repeat (3) tick();
    n_checks++;
    if (ovf_cnt !== 8'd255 || count !== 3'd0)
      $display("FAIL ovf_saturate got ovf=%0d cnt=%0d expected 255/0", ovf_cnt, count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_full();
    test_exception();
    test_drop();
`ifdef MUL_WB_SAT_EN
    test_sat();
`endif
    test_reset_mid();
    test_random();
    test_ovf_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
